// File: rtl/hazard_unit.sv
// hazard_unit: in-order pipeline hazard detection and forwarding selection.
// Keeps a small table describing the DEPTH instructions behind ID. From that
// table and the ID-stage operands it combinationally produces:
//   stall  - load-use stall, asserted while a load's result is not yet forwardable
//   flush  - squash IF/ID on a taken branch; a flush always overrides a stall
//   fwd_a/fwd_b - operand source (0 = register file, k = producer k stages older)
// Optional macro HAZARD_STATS_EN builds saturating 16-bit stall/flush event
// counters. When the macro is undefined, both counter outputs read 0.
module hazard_unit #(
    parameter int REG_AW   = 5,
    parameter int DEPTH    = 3,
    parameter int LOAD_LAT = 2,
    localparam int FW_W    = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_wr_en,
    input  logic              id_is_load,
    input  logic [REG_AW-1:0] id_wr_reg,
    input  logic              br_taken,
    output logic              stall,
    output logic              flush,
    output logic [FW_W-1:0]   fwd_a,
    output logic [FW_W-1:0]   fwd_b,
    output logic [15:0]       stall_cnt,
    output logic [15:0]       flush_cnt
);

    // Entry k describes the instruction k stages older than ID.
    // Only the valid bits are reset. The register and load fields are
    // don't-care whenever their entry is invalid.
    logic [DEPTH:1]    ent_vld;
    logic [REG_AW-1:0] ent_reg  [1:DEPTH];
    logic              ent_load [1:DEPTH];

    logic [DEPTH:1]    match_a;
    logic [DEPTH:1]    match_b;
    logic              load_use;
    logic              ent1_en;

    // Per-entry source matching. Register 0 and unused sources never match.
    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 1; k <= DEPTH; k++) begin
            match_a[k] = id_use_rs && (id_rs != '0) && ent_vld[k] && (ent_reg[k] == id_rs);
            match_b[k] = id_use_rt && (id_rt != '0) && ent_vld[k] && (ent_reg[k] == id_rt);
        end
    end

    // A load-use hazard exists while the matched load sits at a stage whose
    // data cannot yet be forwarded (k < LOAD_LAT).
    always_comb begin
        load_use = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            if (k < LOAD_LAT && ent_load[k] && (match_a[k] || match_b[k]))
                load_use = 1'b1;
        end
    end

    // Stall and flush. A taken branch squashes ID, so it suppresses any stall.
    always_comb begin
        flush = br_taken;
        stall = id_valid && !br_taken && load_use;
    end

    // Forwarding select: scan from the oldest entry to the youngest so the
    // youngest matching producer wins. Force 0 while stalled.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH; k >= 1; k--) begin
            if (match_a[k]) fwd_a = FW_W'(k);
            if (match_b[k]) fwd_b = FW_W'(k);
        end
        if (stall) begin
            fwd_a = '0;
            fwd_b = '0;
        end
    end

    // Entry 1 receives a real producer only if ID advances and writes a
    // nonzero register. Otherwise entry 1 becomes a bubble.
    always_comb begin
        ent1_en = id_valid && id_wr_en && (id_wr_reg != '0) && !stall && !flush;
    end

    // Valid bits shift toward older stages. Reset clears them asynchronously,
    // which drops a pending stall without waiting for a clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ent_vld <= '0;
        end else begin
            for (int k = DEPTH; k >= 2; k--)
                ent_vld[k] <= ent_vld[k-1];
            ent_vld[1] <= ent1_en;
        end
    end

    // Register and load fields shift together with their valid bits.
    always_ff @(posedge clk) begin
        for (int k = DEPTH; k >= 2; k--) begin
            ent_reg[k]  <= ent_reg[k-1];
            ent_load[k] <= ent_load[k-1];
        end
        ent_reg[1]  <= id_wr_reg;
        ent_load[1] <= id_is_load;
    end

`ifdef HAZARD_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Saturating event counters, sampled on every clock edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall) stall_cnt <= sat_inc(stall_cnt);
            if (flush) flush_cnt <= sat_inc(flush_cnt);
        end
    end
`else
    // Without statistics, both counters are tied to 0.
    always_comb begin
        stall_cnt = '0;
        flush_cnt = '0;
    end
`endif

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 Parameter REG_AW, default 5, register-address width.
REQ-002 Parameter DEPTH, default 3, number of in-flight stages tracked behind ID (EX=1, MEM=2, WB=3); legal range 2..8.
REQ-003 Parameter LOAD_LAT, default 2, stage index at which load data first becomes forwardable; legal range 1..DEPTH.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_rs, id_rt  in  REG_AW each  source registers of the ID instruction.
REQ-008 id_use_rs, id_use_rt  in  1 each  the ID instruction actually reads that source.
REQ-009 id_wr_en, id_is_load  in  1 each  the ID instruction writes a register / is a load.
REQ-010 id_wr_reg  in  REG_AW  destination register of the ID instruction.
REQ-011 br_taken  in  1  branch resolved taken this cycle (squash IF and ID).
REQ-012 stall  out  1  hold PC and IF/ID, inject bubble.
REQ-013 flush  out  1  squash IF/ID contents.
REQ-014 fwd_a, fwd_b  out  FW_W = $clog2(DEPTH+1)  operand source: 0 = register file, k = result of instruction k stages older.
REQ-015 stall_cnt, flush_cnt  out  16 each  event counters (see Configuration).

Function
REQ-016 The block SHALL hold a registered table of DEPTH entries {valid, wr_reg, is_load}; entry k describes the instruction k stages older than ID.
REQ-017 Each clock edge, entries SHALL shift k -> k+1; entry DEPTH SHALL be discarded.
REQ-018 Entry 1 SHALL load {1, id_wr_reg, id_is_load} only when id_valid=1, id_wr_en=1, id_wr_reg!=0, stall=0 and flush=0; otherwise entry 1 SHALL become invalid (bubble).
REQ-019 A source SHALL match entry k when it is in use, is nonzero, equals the entry's wr_reg, and the entry is valid; register 0 SHALL never match.
REQ-020 stall SHALL be 1 (combinationally) when id_valid=1, br_taken=0, and either source matches a load entry with k < LOAD_LAT.
REQ-021 flush SHALL equal br_taken combinationally; when br_taken=1, stall SHALL be 0 (flush wins).
REQ-022 fwd_a/fwd_b SHALL be the smallest k whose entry matches rs/rt (youngest producer wins); 0 when there is no match, or when stall=1.
REQ-023 A stalled instruction SHALL re-evaluate every cycle; stall SHALL drop in the cycle the load reaches k = LOAD_LAT, with fwd pointing at that k.
REQ-024 All outputs except the counters SHALL be purely combinational from the table and inputs; zero added latency.
REQ-025 Producers beyond DEPTH SHALL be treated as already written back (fwd = 0).

Reset
REQ-026 While reset=1, all table entries SHALL be invalid and both counters SHALL be 0, asynchronously. Outputs therefore read stall=0, fwd_a=fwd_b=0, flush=br_taken.
REQ-027 Reset asserted mid-stall SHALL release the stall immediately, without waiting for a clock edge.

Configuration
REQ-028 Macro HAZARD_STATS_EN: when defined, stall_cnt SHALL increment on every clock with stall=1, and flush_cnt SHALL increment on every clock with flush=1; both SHALL saturate at 0xFFFF.
REQ-029 Without HAZARD_STATS_EN, the counter logic SHALL not be built, and both counter outputs SHALL be tied to 0.

Verification
REQ-030 Scenario: after reset, an instruction in ID writes r5 (non-load); next cycle the ID instruction reads rs=r5 -> fwd_a=1, stall=0; one cycle later, reading r5 again -> fwd_a=2.
REQ-031 Scenario: a load to r7 enters; next ID instruction reads rt=r7 -> stall=1 for exactly 1 cycle with a bubble in entry 1; the next cycle gives stall=0, fwd_b=2; with HAZARD_STATS_EN, stall_cnt=1.
REQ-032 Scenario: r3 is written by two instructions in back-to-back cycles; the ID instruction reads r3 -> fwd_a=1 (youngest producer), not 2.
REQ-033 Scenario: an instruction writes r0, then the ID instruction reads r0 -> fwd_a=0, stall=0.
REQ-034 Scenario: a load-use stall is pending and br_taken=1 in the same cycle -> flush=1, stall=0, entry 1 becomes a bubble; with HAZARD_STATS_EN, flush_cnt=1.
REQ-035 Scenario: reset is pulsed asynchronously while stall=1 -> stall=0 and counters=0 before the next clk edge; the first instruction after reset sees fwd=0.
